// File: rtl/inst_sram_like_slave_pkg.sv
// Shared constants and the response-queue entry type for the instruction SRAM-like slave.
package inst_sram_like_slave_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;
  localparam int DELAY_MAX = 15;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [31:0]      data;
    logic             dvalid;
    logic [CNT_W-1:0] cnt;
  } resp_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_sram_like_slave_if.sv
// Instruction fetch handshake bus (request/addr_ok, data_ok/rdata).
interface inst_sram_like_slave_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/inst_sram_like_slave_resp_fifo.sv
// In-order response queue; RAM data is forwarded or captured one cycle after accept.
// INST_RESP_DELAY_EN adds a per-entry countdown of DELAY cycles before a response may leave.
module inst_resp_fifo
  import inst_sram_like_slave_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DELAY = 3,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             push_wr,
  input  logic [31:0]      ram_rdata,
  output logic             pop,
  output logic [31:0]      pop_data,
  output logic [PTR_W:0]   count
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0 ||
      DELAY < 0 || DELAY > DELAY_MAX) begin : g_param_chk
    $error("inst_resp_fifo: DEPTH or DELAY out of range");
  end

`ifdef INST_RESP_DELAY_EN
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(DELAY);
`else
  localparam logic [CNT_W-1:0] LOAD_CNT = '0;
`endif

  resp_entry_t      mem [DEPTH];
  resp_entry_t      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic             fill_vld;
  logic             fwd;

  // fill_* marks the entry whose RAM word arrives on ram_rdata this cycle
  assign head     = mem[rd_ptr];
  assign fwd      = fill_vld && (fill_ptr == rd_ptr);
  assign pop      = (count != '0) && (head.cnt == '0) && (head.dvalid || fwd);
  assign pop_data = head.dvalid ? head.data : ram_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_ptr <= '0;
      fill_vld <= 1'b0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      fill_vld <= push && !push_wr;
      if (push) begin
        fill_ptr <= wr_ptr;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      for (int i = 0; i < DEPTH; i++) begin
`ifdef INST_RESP_DELAY_EN
        if (mem[i].cnt != '0) mem[i].cnt <= mem[i].cnt - CNT_W'(1);
`endif
        if (fill_vld && fill_ptr == PTR_W'(i)) begin
          mem[i].data   <= ram_rdata;
          mem[i].dvalid <= 1'b1;
        end
        if (pop && rd_ptr == PTR_W'(i)) mem[i].dvalid <= 1'b0;
        // writes carry no RAM data, so they are ready with zero immediately
        if (push && wr_ptr == PTR_W'(i)) begin
          mem[i].data   <= '0;
          mem[i].dvalid <= push_wr;
          mem[i].cnt    <= LOAD_CNT;
        end
      end
    end
  end

endmodule

// File: rtl/inst_sram_like_slave.sv
// Instruction SRAM-like slave: accepts fetches, drives the backing RAM, returns in-order responses.
// Optional INST_RESP_DELAY_EN adds DELAY extra cycles of response latency.
module inst_sram_like_slave
  import inst_sram_like_slave_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4,
  parameter int DELAY  = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  inst_sram_like_slave_if.slave bus,
  output logic                 ram_en,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [31:0]          ram_rdata
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic           addr_ok;
  logic           accept;
  logic           pop;
  logic [31:0]    pop_data;
  logic [31:0]    rdata_q;
  logic [PTR_W:0] count;
  logic           unused_bits;

  // gated by resetn so addr_ok is low during reset and rises right after release
  assign addr_ok  = resetn && (count < DEPTH_C);
  assign accept   = bus.inst_req && addr_ok;
  assign ram_en   = accept && !bus.inst_wr;
  assign ram_addr = ram_en ? bus.inst_addr[ADDR_W+1:2] : '0;

  assign bus.inst_addr_ok = addr_ok;
  assign bus.inst_data_ok = pop;
  assign bus.inst_rdata   = pop ? pop_data : rdata_q;

  assign unused_bits = ^{bus.inst_size, bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else if (pop) rdata_q <= pop_data;
  end

  inst_resp_fifo #(
    .DEPTH (DEPTH),
    .DELAY (DELAY)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_wr   (bus.inst_wr),
    .ram_rdata (ram_rdata),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (count)
  );

endmodule

// File: doc/inst_sram_like_slave.md
INST_SRAM_LIKE_SLAVE -- requirements
Module: inst_sram_like_slave

Interface
REQ-001 Parameter ADDR_W, default 16: word-address width of the backing instruction RAM.
REQ-002 Parameter DEPTH, default 4, power of two from 2 to 16: maximum outstanding requests.
REQ-003 Parameter DELAY, default 3, range 0..15: extra response latency, used only when INST_RESP_DELAY_EN is defined.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 inst_req  in  1  fetch request valid.
REQ-007 inst_wr  in  1  write flag; 1 marks a write request.
REQ-008 inst_size  in  2  access size; ignored, always treated as a full word.
REQ-009 inst_addr  in  32  byte address.
REQ-010 inst_addr_ok  out  1  request accepted this cycle.
REQ-011 inst_data_ok  out  1  one-cycle response pulse.
REQ-012 inst_rdata  out  32  response data, valid only while inst_data_ok=1.
REQ-013 ram_en  out  1  backing RAM read enable.
REQ-014 ram_addr  out  ADDR_W  RAM word address.
REQ-015 ram_rdata  in  32  RAM data, valid exactly one cycle after ram_en.

Function
REQ-016 Request handshake: a request SHALL be accepted in any cycle with inst_req=1 and inst_addr_ok=1.
REQ-017 inst_addr_ok SHALL equal (outstanding count < DEPTH), combinationally, independent of inst_req.
REQ-018 Read accept: ram_en=1 in the same cycle; ram_addr=inst_addr[ADDR_W+1:2]; inst_addr[1:0] ignored (word-aligned read, no alignment fault).
REQ-019 Write accept: ram_en=0; the request is still accepted and answered with inst_rdata=32'd0.
REQ-020 Responses SHALL be returned strictly in acceptance order, at most one inst_data_ok per cycle; the consumer has no back-pressure, so every pulse is final.
REQ-021 Base latency: a request accepted in cycle N SHALL produce inst_data_ok in cycle N+1, with inst_rdata=ram_rdata of that cycle.
REQ-022 Back-to-back accepts in consecutive cycles SHALL produce back-to-back inst_data_ok pulses.
REQ-023 Outstanding count SHALL be +1 on accept and -1 on inst_data_ok; with both in one cycle it is unchanged; it never exceeds DEPTH and never underflows.
REQ-024 Storage: a DEPTH-entry response queue with pointers wrapping modulo DEPTH.
REQ-025 Each queue entry holds data, a data-valid bit and a countdown; RAM data SHALL be captured into its entry in cycle N+1 when not forwarded directly.
REQ-026 Full boundary: at count=DEPTH, inst_addr_ok=0 and inst_req is ignored.
REQ-027 Full boundary: a data_ok in the same cycle as full SHALL re-enable inst_addr_ok in the next cycle only (no same-cycle bypass).
REQ-028 Empty boundary: with count=0, inst_data_ok SHALL be 0.
REQ-029 inst_rdata SHALL hold its last value when inst_data_ok=0.

Reset
REQ-030 While resetn=0: inst_addr_ok=0, inst_data_ok=0, inst_rdata=0, ram_en=0, ram_addr=0, count=0, pointers=0.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding requests; no inst_data_ok is ever issued for them.
REQ-032 inst_addr_ok SHALL rise in the first cycle after resetn deasserts.

Configuration
REQ-033 Macro INST_RESP_DELAY_EN defined: every response SHALL be emitted no earlier than cycle N+1+DELAY, using a per-entry countdown loaded with DELAY on accept.
REQ-034 Macro INST_RESP_DELAY_EN defined: the head entry SHALL be emitted in the first cycle its countdown is 0 and its data is valid; ordering and single-pulse rules still apply.
REQ-035 Macro INST_RESP_DELAY_EN undefined: DELAY has no effect, the countdown logic is absent, and latency is exactly 1.

Structure
REQ-036 Shared package: the DEPTH and DELAY bounds, the queue entry struct {data, data-valid, countdown} and the pointer width constant.
REQ-037 The response queue SHALL be one sub-module, inst_resp_fifo; the request/RAM control stays in the top level.

Verification
REQ-038 Single read: RAM word 5=32'h24020001; read of addr 32'hbfc00014 accepted in cycle 10 -> ram_addr=5 in cycle 10; data_ok with rdata=32'h24020001 in cycle 11 only.
REQ-039 Streaming: 8 consecutive reads of words 0..7 -> 8 consecutive data_ok pulses, data in order, addr_ok held 1.
REQ-040 Full, DELAY=3, macro defined: 5 requests issued back-to-back -> addr_ok=0 after 4 accepts; first data_ok 4 cycles after the first accept; the 5th request is accepted in the cycle after that data_ok.
REQ-041 Write interleave: read word 2, write, read word 3 -> three pulses in order with rdata {word2, 32'd0, word3}; ram_en=0 in the write cycle.
REQ-042 Reset: resetn pulsed low with 3 requests outstanding -> no data_ok afterwards; count=0; addr_ok=1 in the first cycle after release.
REQ-043 Misaligned read of addr 32'hbfc00016 -> ram_addr=5, rdata=word 5.
